// File: rtl/edge_detect_multi.sv
`default_nettype none
// ============================================================================
// Module      : edge_detect_multi
// Description : Multi-channel synchronised, debounced edge detector with
//               per-channel mode select, one-cycle qualified edge pulses,
//               sticky write-1-to-clear status flags and a combined
//               interrupt output.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   CH          number of independent channels (1..32)
//   SYNC_STAGES synchroniser flops per channel (0..3, 0 = bypass)
//   FILT_CNT    cycles a new synchronised level must persist (1..255)
// Ports
//   clk_i       single clock, all state on the rising edge
//   rstn_i      asynchronous active-low reset
//   sign_i      [CH]   raw input levels
//   mode_i      [2*CH] per-channel mode: 00 off, 01 rise, 10 fall, 11 both
//   clear_i     [CH]   write-1-to-clear for status_o
//   irq_en_i    [CH]   per-channel interrupt enable
//   level_o     [CH]   filtered level
//   pulse_o     [CH]   one-cycle qualified edge pulse
//   status_o    [CH]   sticky edge-seen flags
//   irq_o              OR over channels of (status_o & irq_en_i)
// ============================================================================
module edge_detect_multi #(
  parameter int CH          = 4,
  parameter int SYNC_STAGES = 2,
  parameter int FILT_CNT    = 4
) (
  input  logic            clk_i,
  input  logic            rstn_i,
  input  logic [CH-1:0]   sign_i,
  input  logic [2*CH-1:0] mode_i,
  input  logic [CH-1:0]   clear_i,
  input  logic [CH-1:0]   irq_en_i,
  output logic [CH-1:0]   level_o,
  output logic [CH-1:0]   pulse_o,
  output logic [CH-1:0]   status_o,
  output logic            irq_o
);

  localparam int              CNT_W    = $clog2(FILT_CNT + 1);
  // Counter value at which the next differing sample completes the run.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILT_CNT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  for (genvar c = 0; c < CH; c++) begin : g_ch

    logic sync_w;

    // ------------------------------------------------------------------
    // Input synchroniser
    // ------------------------------------------------------------------
    if (SYNC_STAGES == 0) begin : g_sync_bypass
      assign sync_w = sign_i[c];
    end else begin : g_sync
      logic [SYNC_STAGES-1:0] sync_q;
      logic [SYNC_STAGES-1:0] sync_d;

      // Shift left by one: new sample enters bit 0, oldest bit drops off.
      always_comb begin
        sync_d = SYNC_STAGES'({sync_q, sign_i[c]});
      end

      always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
          sync_q <= '0;
        end else begin
          sync_q <= sync_d;
        end
      end

      assign sync_w = sync_q[SYNC_STAGES-1];
    end

    // ------------------------------------------------------------------
    // Debounce filter
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             level_q;
    logic             level_d;

    always_comb begin
      cnt_d   = cnt_q;
      level_d = level_q;
      if (sync_w == level_q) begin
        cnt_d = '0;
      end else if (cnt_q == CNT_LAST) begin
        // FILT_CNT-th consecutive differing sample: accept the new level.
        cnt_d   = '0;
        level_d = ~level_q;
      end else begin
        cnt_d = cnt_q + CNT_ONE;
      end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
        cnt_q   <= '0;
        level_q <= 1'b0;
      end else begin
        cnt_q   <= cnt_d;
        level_q <= level_d;
      end
    end

    // ------------------------------------------------------------------
    // Edge qualification, pulse and sticky status
    // ------------------------------------------------------------------
    logic       prev_q;
    logic       pulse_q;
    logic       pulse_d;
    logic       status_q;
    logic       status_d;
    logic       rise_w;
    logic       fall_w;
    logic [1:0] mode_w;

    // Edges derive only from the filtered level history, so a change of
    // mode alone can never manufacture a pulse.
    assign rise_w = level_q & ~prev_q;
    assign fall_w = ~level_q & prev_q;
    assign mode_w = mode_i[2*c +: 2];

    always_comb begin
      pulse_d  = (rise_w & mode_w[0]) | (fall_w & mode_w[1]);
      // A new pulse overrides a simultaneous clear.
      status_d = pulse_d | (status_q & ~clear_i[c]);
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
        prev_q   <= 1'b0;
        pulse_q  <= 1'b0;
        status_q <= 1'b0;
      end else begin
        prev_q   <= level_q;
        pulse_q  <= pulse_d;
        status_q <= status_d;
      end
    end

    assign level_o[c]  = level_q;
    assign pulse_o[c]  = pulse_q;
    assign status_o[c] = status_q;

  end : g_ch

  // Combinational so that enabling an already-flagged channel is immediate.
  assign irq_o = |(status_o & irq_en_i);

endmodule : edge_detect_multi
`default_nettype wire

// File: tb/tb_edge_detect_multi.sv
`default_nettype none
// ============================================================================
// Module      : tb_edge_detect_multi
// Description : Self-checking bench for edge_detect_multi. A behavioural
//               model (sample-delay queue, persistence window, pending-edge
//               bookkeeping) is compared with the DUT after every clock edge;
//               directed scenarios add hand-computed literal expectations,
//               followed by a randomized soak.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_edge_detect_multi;

  localparam int CH          = 4;
  localparam int SYNC_STAGES = 2;
  localparam int FILT_CNT    = 4;
  localparam int LAT         = SYNC_STAGES + FILT_CNT + 1;

  logic            clk_i    = 1'b0;
  logic            rstn_i   = 1'b0;
  logic [CH-1:0]   sign_i   = '0;
  logic [2*CH-1:0] mode_i   = '0;
  logic [CH-1:0]   clear_i  = '0;
  logic [CH-1:0]   irq_en_i = '0;
  logic [CH-1:0]   level_o;
  logic [CH-1:0]   pulse_o;
  logic [CH-1:0]   status_o;
  logic            irq_o;

  int tests = 0;
  int fails = 0;

  edge_detect_multi #(
    .CH          (CH),
    .SYNC_STAGES (SYNC_STAGES),
    .FILT_CNT    (FILT_CNT)
  ) u_dut (
    .clk_i    (clk_i),
    .rstn_i   (rstn_i),
    .sign_i   (sign_i),
    .mode_i   (mode_i),
    .clear_i  (clear_i),
    .irq_en_i (irq_en_i),
    .level_o  (level_o),
    .pulse_o  (pulse_o),
    .status_o (status_o),
    .irq_o    (irq_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // --------------------------------------------------------------------------
  // Behavioural model
  //   dly[c] : samples not yet visible to the filter (SYNC_STAGES deep)
  //   win[c] : last FILT_CNT samples the filter has seen; the level flips when
  //            every one of them disagrees with the current level
  //   pend[c]: edge produced by a flip on the previous clock (0 none,1 rise,2 fall)
  // --------------------------------------------------------------------------
  bit            dly [CH][$];
  bit            win [CH][$];
  logic [CH-1:0] m_level;
  logic [CH-1:0] m_pulse;
  logic [CH-1:0] m_status;
  int            pend [CH];

  task automatic model_reset();
    for (int c = 0; c < CH; c++) begin
      dly[c].delete();
      win[c].delete();
      for (int i = 0; i < SYNC_STAGES; i++) dly[c].push_back(1'b0);
      for (int i = 0; i < FILT_CNT; i++)    win[c].push_back(1'b0);
      pend[c] = 0;
    end
    m_level  = '0;
    m_pulse  = '0;
    m_status = '0;
  endtask

  task automatic model_step();
    for (int c = 0; c < CH; c++) begin
      bit         s;
      bit         all_diff;
      logic [1:0] m;
      m = mode_i[2*c +: 2];
      m_pulse[c]  = (pend[c] == 1 && m[0]) || (pend[c] == 2 && m[1]);
      m_status[c] = m_pulse[c] ? 1'b1 : (clear_i[c] ? 1'b0 : m_status[c]);
      dly[c].push_back(sign_i[c]);
      s = dly[c].pop_front();
      win[c].push_back(s);
      void'(win[c].pop_front());
      all_diff = 1'b1;
      for (int i = 0; i < win[c].size(); i++)
        if (win[c][i] == m_level[c]) all_diff = 1'b0;
      pend[c] = 0;
      if (all_diff) begin
        pend[c]    = m_level[c] ? 2 : 1;
        m_level[c] = ~m_level[c];
      end
    end
  endtask

  always @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) model_reset();
    else         model_step();
  end

  // Per-cycle comparison, away from the active edge.
  always @(posedge clk_i) begin
    #1;
    chk("model_level",  32'(level_o),  32'(m_level));
    chk("model_pulse",  32'(pulse_o),  32'(m_pulse));
    chk("model_status", 32'(status_o), 32'(m_status));
    chk("model_irq",    32'(irq_o),    32'(|(m_status & irq_en_i)));
  end

  // One clock: wait for the edge, look at pulse_o[ch], return at the negedge.
  task automatic tick_chk(input string name, input int ch, input bit exp);
    @(posedge clk_i);
    #1;
    chk(name, 32'(pulse_o[ch]), 32'(exp));
    @(negedge clk_i);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk_i);
  endtask

  initial begin
    // ---------------- reset state ----------------
    mode_i   = 8'b01_10_11_01;   // ch3 rise, ch2 fall, ch1 both, ch0 rise
    irq_en_i = 4'hF;
    tick(3);
    chk("reset_level",  32'(level_o),  32'h0);
    chk("reset_pulse",  32'(pulse_o),  32'h0);
    chk("reset_status", 32'(status_o), 32'h0);
    chk("reset_irq",    32'(irq_o),    32'h0);
    rstn_i = 1'b1;
    tick(4);

    // ---------------- ch0 rise, latency 7 ----------------
    sign_i[0] = 1'b1;
    for (int k = 1; k <= LAT + 2; k++) tick_chk("ch0_rise_pulse", 0, k == LAT);
    chk("ch0_status", 32'(status_o[0]), 32'h1);
    chk("ch0_irq",    32'(irq_o),       32'h1);

    // ---------------- ch1 glitch then real pulse ----------------
    sign_i[1] = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      if (k == 4) sign_i[1] = 1'b0;          // high for 3 edges only
      tick_chk("ch1_glitch_pulse", 1, 1'b0);
    end
    chk("ch1_glitch_level",  32'(level_o[1]),  32'h0);
    chk("ch1_glitch_status", 32'(status_o[1]), 32'h0);
    sign_i[1] = 1'b1;
    for (int k = 1; k <= 15; k++) begin
      if (k == 6) sign_i[1] = 1'b0;          // high for 5 edges, then held low
      tick_chk("ch1_rise_fall_pulse", 1, (k == 7) || (k == 12));
    end
    chk("ch1_level_after", 32'(level_o[1]), 32'h0);

    // ---------------- ch2 fall-only mode, rising input ----------------
    sign_i[2] = 1'b1;
    for (int k = 1; k <= 10; k++) tick_chk("ch2_no_pulse", 2, 1'b0);
    chk("ch2_level",  32'(level_o[2]),  32'h1);
    chk("ch2_status", 32'(status_o[2]), 32'h0);

    // ---------------- ch3 set wins over clear ----------------
    sign_i[3] = 1'b1;
    for (int k = 1; k <= LAT + 1; k++) tick_chk("ch3_first_pulse", 3, k == LAT);
    sign_i[3] = 1'b0;
    tick(10);
    chk("ch3_status_held", 32'(status_o[3]), 32'h1);
    sign_i[3] = 1'b1;
    for (int k = 1; k <= LAT; k++) begin
      if (k == LAT) clear_i[3] = 1'b1;
      tick_chk("ch3_second_pulse", 3, k == LAT);
    end
    clear_i[3] = 1'b0;
    chk("ch3_set_wins", 32'(status_o[3]), 32'h1);
    tick(3);
    clear_i[3] = 1'b1;
    @(posedge clk_i); #1;
    chk("ch3_cleared", 32'(status_o[3]), 32'h0);
    @(negedge clk_i);
    clear_i[3] = 1'b0;

    // ---------------- ch0 + ch1 simultaneous, irq hold ----------------
    clear_i = 4'hF;
    tick(1);
    clear_i = 4'h0;
    chk("all_cleared", 32'(status_o), 32'h0);
    mode_i[1:0] = 2'b11;                      // mode change alone: no pulse
    tick(3);
    sign_i[0] = 1'b0;
    sign_i[1] = 1'b1;
    for (int k = 1; k <= LAT + 1; k++) begin
      @(posedge clk_i); #1;
      chk("dual_pulse", 32'(pulse_o[1:0]), (k == LAT) ? 32'h3 : 32'h0);
      @(negedge clk_i);
    end
    chk("dual_status", 32'(status_o), 32'h3);
    irq_en_i = 4'h0;
    #1 chk("irq_disabled", 32'(irq_o), 32'h0);
    irq_en_i = 4'h1;
    #1 chk("irq_enable_immediate", 32'(irq_o), 32'h1);
    irq_en_i = 4'hF;
    clear_i  = 4'h1;
    tick(1);
    clear_i  = 4'h0;
    chk("irq_one_left", 32'(irq_o), 32'h1);
    clear_i  = 4'h2;
    tick(1);
    clear_i  = 4'h0;
    chk("irq_none_left", 32'(irq_o), 32'h0);

    // ---------------- reset with inputs high ----------------
    mode_i = 8'b01_01_01_01;
    sign_i = 4'hF;
    tick(2);
    rstn_i = 1'b0;
    #1;
    chk("async_rst_level",  32'(level_o),  32'h0);
    chk("async_rst_status", 32'(status_o), 32'h0);
    chk("async_rst_irq",    32'(irq_o),    32'h0);
    tick(3);
    rstn_i = 1'b1;
    for (int k = 1; k <= LAT + 2; k++) begin
      @(posedge clk_i); #1;
      chk("post_reset_pulse", 32'(pulse_o), (k == LAT) ? 32'hF : 32'h0);
      @(negedge clk_i);
    end

    // ---------------- reset mid-filter ----------------
    rstn_i = 1'b0;
    tick(2);
    rstn_i = 1'b1;
    tick(3 + 1);                               // to edge 3 of filtering
    rstn_i = 1'b0;
    #1;
    chk("midfilt_level", 32'(level_o), 32'h0);
    chk("midfilt_pulse", 32'(pulse_o), 32'h0);
    sign_i = 4'h0;
    tick(2);
    rstn_i = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk_i); #1;
      chk("no_stale_pulse", 32'(pulse_o | level_o), 32'h0);
      @(negedge clk_i);
    end

    // ---------------- randomized soak ----------------
    for (int n = 0; n < 3000; n++) begin
      for (int c = 0; c < CH; c++) begin
        if ($urandom_range(0, 5) == 0) sign_i[c] = ~sign_i[c];
        if ($urandom_range(0, 60) == 0) mode_i[2*c +: 2] = 2'($urandom_range(0, 3));
        clear_i[c] = ($urandom_range(0, 15) == 0);
      end
      if ($urandom_range(0, 30) == 0) irq_en_i = CH'($urandom);
      if (!rstn_i) rstn_i = 1'b1;
      else if ($urandom_range(0, 400) == 0) rstn_i = 1'b0;
      tick(1);
    end
    rstn_i  = 1'b1;
    clear_i = '0;
    tick(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_edge_detect_multi
`default_nettype wire
